// File: rtl/nios2_debug_pkg.sv
// Shared types and jdo field positions for the Nios II debug OCI-memory arbiter.
package nios2_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_CAP,
    ST_J_WR,
    ST_C_RD,
    ST_C_CAP,
    ST_C_ACK,
    ST_C_WR
  } state_e;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_JTAG = 1'b1
  } grant_e;

  localparam int READ_BIT  = 35;
  localparam int LOAD_BIT  = 34;
  localparam int ADDR_LSB  = 17;
  localparam int WDATA_MSB = 34;
  localparam int WDATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_jtag_cmd_capture.sv
// Captures decoded JTAG OCI-memory strobes: pending op, write data, the
// auto-incrementing word address and the sticky overrun flag.
module nios2_debug_jtag_cmd_capture
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              op_done,
  output logic              pending,
  output logic              op_write,
  output logic [31:0]       wdata,
  output logic [ADDR_W-1:0] jaddr,
  output logic              overrun
);

  logic              pending_q, pending_d;
  logic              op_write_q, op_write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              overrun_q, overrun_d;
  logic              strobe;
  logic              accept;
  logic              unused_jdo;

  assign strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // The op finishing this cycle frees the slot, so a strobe landing on it is taken.
  assign accept     = strobe && (!pending_q || op_done);
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    pending_d  = pending_q;
    op_write_d = op_write_q;
    wdata_d    = wdata_q;
    jaddr_d    = jaddr_q;
    overrun_d  = overrun_q;

    if (op_done) begin
      pending_d = 1'b0;
      jaddr_d   = jaddr_q + ADDR_W'(1);
    end

    if (accept) begin
      if (take_action_ocimem_a) begin
        if (jdo[LOAD_BIT]) begin
          jaddr_d   = jdo[ADDR_LSB +: ADDR_W];
          overrun_d = 1'b0;
        end
        if (jdo[READ_BIT]) begin
          pending_d  = 1'b1;
          op_write_d = 1'b0;
        end
      end else if (take_no_action_ocimem_a) begin
        pending_d  = 1'b1;
        op_write_d = 1'b0;
      end else begin
        pending_d  = 1'b1;
        op_write_d = 1'b1;
        wdata_d    = jdo[WDATA_MSB:WDATA_LSB];
      end
    end else if (strobe) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= only, so every flop samples the pre-edge values.
    if (!rst_n) begin
      pending_q  <= 1'b0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      jaddr_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      op_write_q <= op_write_d;
      wdata_q    <= wdata_d;
      jaddr_q    <= jaddr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pending  = pending_q;
  assign op_write = op_write_q;
  assign wdata    = wdata_q;
  assign jaddr    = jaddr_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the single-port debug RAM between JTAG host commands and the CPU
// debug-slave port, round-robin on contention.
module nios2_debug_ocimem_arbiter
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_byteen,
  output logic              ram_wren,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [31:0]       cpu_readdata_q, cpu_readdata_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;

  logic              jtag_pending;
  logic              jtag_op_write;
  logic [31:0]       jtag_wdata;
  logic [ADDR_W-1:0] jaddr;
  logic              jtag_done;
  logic              cpu_req;
  logic              jtag_wins;

  nios2_debug_jtag_cmd_capture #(
    .ADDR_W(ADDR_W)
  ) u_cmd_capture (
    .clk                     (clk),
    .rst_n                   (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .op_done                 (jtag_done),
    .pending                 (jtag_pending),
    .op_write                (jtag_op_write),
    .wdata                   (jtag_wdata),
    .jaddr                   (jaddr),
    .overrun                 (jtag_overrun)
  );

  assign cpu_req   = cpu_read | cpu_write;
  assign jtag_done = (state_q == ST_J_CAP) || (state_q == ST_J_WR);
  // On a tie JTAG wins only if the CPU held the previous grant.
  assign jtag_wins = jtag_pending && (!cpu_req || (last_grant_q == GRANT_CPU));

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cpu_readdata_d = cpu_readdata_q;
    mon_dreg_d     = mon_dreg_q;

    unique case (state_q)
      ST_IDLE: begin
        if (jtag_wins) begin
          state_d      = jtag_op_write ? ST_J_WR : ST_J_RD;
          last_grant_d = GRANT_JTAG;
        end else if (cpu_req) begin
          state_d      = cpu_write ? ST_C_WR : ST_C_RD;
          last_grant_d = GRANT_CPU;
        end
      end
      ST_J_RD:  state_d = ST_J_CAP;
      ST_J_CAP: begin
        mon_dreg_d = ram_rdata;
        state_d    = ST_IDLE;
      end
      ST_J_WR:  state_d = ST_IDLE;
      ST_C_RD:  state_d = ST_C_CAP;
      ST_C_CAP: begin
        cpu_readdata_d = ram_rdata;
        state_d        = ST_C_ACK;
      end
      ST_C_ACK: state_d = ST_IDLE;
      ST_C_WR:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GRANT_CPU;
      cpu_readdata_q <= '0;
      mon_dreg_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cpu_readdata_q <= cpu_readdata_d;
      mon_dreg_q     <= mon_dreg_d;
    end
  end

  // RAM port is decoded straight from the state so reset kills a write at once.
  always_comb begin
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_byteen = '0;
    ram_wren   = 1'b0;
    case (state_q)
      ST_J_RD: ram_addr = jaddr;
      ST_J_WR: begin
        ram_addr   = jaddr;
        ram_wdata  = jtag_wdata;
        ram_byteen = 4'hF;
        ram_wren   = 1'b1;
      end
      ST_C_RD: ram_addr = cpu_address;
      ST_C_WR: begin
        ram_addr   = cpu_address;
        ram_wdata  = cpu_writedata;
        ram_byteen = cpu_byteenable;
        ram_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_waitrequest = cpu_req && (state_q != ST_C_ACK) && (state_q != ST_C_WR);
  assign cpu_readdata    = cpu_readdata_q;
  assign MonDReg         = mon_dreg_q;
  assign jtag_busy       = jtag_pending;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Directed bench for the OCI-memory arbiter with a 1-cycle-latency RAM model.
module tb_nios2_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic        jtag_overrun;

  int total = 0;
  int bad   = 0;

  nios2_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_byteen              (ram_byteen),
    .ram_wren                (ram_wren),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  always #5 clk = ~clk;

  // RAM model: image loaded on the first edge, byte-enabled writes, registered read.
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  int          wren_cnt = 0;

  function automatic logic [31:0] image(input int a);
    case (a)
      8'h01:   return 32'h0101_0101;
      8'h10:   return 32'hDEAD_BEEF;
      8'h11:   return 32'h1234_5678;
      8'h20:   return 32'hCAFE_F00D;
      8'h30:   return 32'hA5A5_A5A5;
      8'h40:   return 32'h1122_3344;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= image(i);
      mem_init <= 1'b1;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      wren_cnt <= wren_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [37:0] jdo_a(input logic rd, input logic ld, input logic [7:0] addr);
    logic [37:0] j;
    j          = '0;
    j[35]      = rd;
    j[34]      = ld;
    j[17 +: 8] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    cpu_address             = '0;
    cpu_read                = 1'b0;
    cpu_write               = 1'b0;
    cpu_writedata           = '0;
    cpu_byteenable          = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_cpu_rdata", cpu_readdata, 32'h0);
    check("rst_wren", ram_wren, 1'b0);
    check("rst_busy", jtag_busy, 1'b0);
    check("rst_overrun", jtag_overrun, 1'b0);
    check("rst_ram_addr", ram_addr, 8'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_ram_byteen", ram_byteen, 4'h0);
    check("rst_waitreq", cpu_waitrequest, 1'b0);

    // JTAG load + read of 0x10
    jdo = jdo_a(1'b1, 1'b1, 8'h10);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    check("jrd_busy_rise", jtag_busy, 1'b1);
    tick();
    tick();
    check("jrd_not_early", MonDReg, 32'h0);
    tick();
    check("jrd_mondreg", MonDReg, 32'hDEAD_BEEF);
    check("jrd_busy_fall", jtag_busy, 1'b0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    repeat (3) tick();
    check("jrd_jaddr_0x11", MonDReg, 32'h1234_5678);

    // JTAG write burst across the address wrap
    jdo = jdo_a(1'b0, 1'b1, 8'hFE);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    check("load_only_no_op", jtag_busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      jdo = jdo_b(32'hB0B0_0000 + 32'(i));
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      tick();
      check("burst_wren", ram_wren, 1'b1);
      tick();
      check("burst_busy_fall", jtag_busy, 1'b0);
    end
    check("burst_mem_fe", mem[8'hFE], 32'hB0B0_0000);
    check("burst_mem_ff", mem[8'hFF], 32'hB0B0_0001);
    check("burst_mem_00", mem[8'h00], 32'hB0B0_0002);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    repeat (3) tick();
    check("burst_jaddr_01", MonDReg, 32'h0101_0101);

    // Overrun: second write strobe while busy is dropped (jaddr = 0x02)
    jdo = jdo_b(32'h0F0F_0F0F);
    take_action_ocimem_b = 1'b1;
    tick();
    jdo = jdo_b(32'hBAD0_BAD0);
    tick();
    take_action_ocimem_b = 1'b0;
    check("ovr_set", jtag_overrun, 1'b1);
    check("ovr_wdata_kept", ram_wdata, 32'h0F0F_0F0F);
    tick();
    check("ovr_mem_02", mem[8'h02], 32'h0F0F_0F0F);
    check("ovr_busy_fall", jtag_busy, 1'b0);
    check("ovr_sticky", jtag_overrun, 1'b1);
    jdo = jdo_a(1'b1, 1'b1, 8'h30);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    check("ovr_cleared", jtag_overrun, 1'b0);
    repeat (3) tick();
    check("ovr_load_read", MonDReg, 32'hA5A5_A5A5);

    // CPU byte write to 0x40
    cpu_address    = 8'h40;
    cpu_writedata  = 32'h00AB_0000;
    cpu_byteenable = 4'b0100;
    cpu_write      = 1'b1;
    #1;
    check("cwr_wait_idle", cpu_waitrequest, 1'b1);
    tick();
    check("cwr_wait_low", cpu_waitrequest, 1'b0);
    check("cwr_wren", ram_wren, 1'b1);
    check("cwr_byteen", ram_byteen, 4'b0100);
    check("cwr_addr", ram_addr, 8'h40);
    tick();
    check("cwr_low_once", cpu_waitrequest, 1'b1);
    cpu_write = 1'b0;
    #1;
    check("cwr_mem_40", mem[8'h40], 32'h11AB_3344);
    tick();

    // Reset in the middle of a CPU write with a JTAG write pending
    cpu_address    = 8'h41;
    cpu_writedata  = 32'hFFFF_FFFF;
    cpu_byteenable = 4'hF;
    cpu_write      = 1'b1;
    jdo = jdo_b(32'h5555_5555);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    check("rmid_in_cwr", ram_wren, 1'b1);
    cnt = wren_cnt;
    reset_n = 1'b0;
    #1;
    check("rmid_wren_drop", ram_wren, 1'b0);
    check("rmid_busy", jtag_busy, 1'b0);
    check("rmid_mondreg", MonDReg, 32'h0);
    check("rmid_ram_addr", ram_addr, 8'h0);
    check("rmid_byteen", ram_byteen, 4'h0);
    cpu_write = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("rmid_no_write", 32'(wren_cnt), 32'(cnt));
    check("rmid_mem_41", mem[8'h41], 32'h0);
    check("rmid_busy_after", jtag_busy, 1'b0);

    // Tie: first goes to JTAG (last_grant reset to CPU), next to CPU
    jdo = jdo_b(32'h7777_0001);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    cpu_address = 8'h20;
    cpu_read    = 1'b1;
    #1;
    check("tie_wait_high", cpu_waitrequest, 1'b1);
    tick();
    check("tie1_jtag_wren", ram_wren, 1'b1);
    check("tie1_jtag_addr", ram_addr, 8'h00);
    jdo = jdo_b(32'h7777_0002);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    check("tie_accept_on_done", jtag_busy, 1'b1);
    check("tie_mem_00", mem[8'h00], 32'h7777_0001);
    check("tie_wait_held", cpu_waitrequest, 1'b1);
    tick();
    check("tie2_cpu_addr", ram_addr, 8'h20);
    check("tie2_cpu_nowren", ram_wren, 1'b0);
    check("tie2_wait_crd", cpu_waitrequest, 1'b1);
    tick();
    check("tie2_wait_ccap", cpu_waitrequest, 1'b1);
    tick();
    check("tie2_wait_ack", cpu_waitrequest, 1'b0);
    check("tie2_rdata", cpu_readdata, 32'hCAFE_F00D);
    cpu_read = 1'b0;
    tick();
    tick();
    check("tie3_jwr_data", ram_wdata, 32'h7777_0002);
    check("tie3_jwr_addr", ram_addr, 8'h01);
    tick();
    check("tie3_mem_01", mem[8'h01], 32'h7777_0002);
    check("tie3_busy_fall", jtag_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
